posit_weight_serializer: RTL and testbench
==========================================

Name: posit_weight_serializer

Overview:
Transmit side of the bit-serial posit weight interface consumed by fp_posit_mul. Accepts parallel posit weight words over a valid/ready handshake. Shifts each word out MSB-first, one bit per clock, on the w/valid pair, with a per-word last marker. The shift length is set by a run-time posit precision, so a word of any supported precision streams as a contiguous bit train into the multiplier.

Parameters:
MAX_WIDTH, 8, widest posit weight supported (bits); in_weight width
PREC_WIDTH, 4, width of precision field
DEFAULT_PREC, 4, precision loaded at reset

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
set  input  1  one-cycle strobe: latch precision
precision  input  PREC_WIDTH  posit width in bits for subsequent words
in_valid  input  1  in_weight holds a word
in_ready  output  1  serializer accepts word this cycle (handshake when in_valid & in_ready)
in_weight  input  MAX_WIDTH  posit word, right-aligned in bits [prec-1:0]; upper bits ignored
w  output  1  serial weight bit
valid  output  1  w is a live bit
last  output  1  w is final (LSB) bit of current word
busy  output  1  word in flight (SHIFT state)

Behaviour:
- Reset (rst=1 at clk edge): w=0, valid=0, last=0, busy=0, in_ready=0 in reset cycle then 1; prec_r=DEFAULT_PREC; shift reg, counter cleared; state IDLE. Reset mid-word aborts the word with no further valid bits.
- prec_r update: on set=1 only while state=IDLE and no handshake this cycle. Value clamped: precision<2 -> 2, precision>MAX_WIDTH -> MAX_WIDTH. set while busy is ignored. The precision value is not reapplied later.
- States: IDLE, SHIFT.
- IDLE: in_ready=1. On handshake, load shreg<=in_weight left-justified to bit prec_r-1 and cnt<=prec_r-1, then go to SHIFT. valid stays 0 in IDLE.
- SHIFT: each cycle drive w=shreg[cnt], valid=1, last=(cnt==0), then cnt<=cnt-1.
  - in_ready=1 only in the cycle where cnt==0.
  - If a handshake occurs on the last bit, load the new word and stay in SHIFT. There is no bubble: the next word's MSB follows the previous LSB on the next cycle.
  - Otherwise return to IDLE after the last bit.
- Latency: the first bit (MSB) is valid on the cycle after the accepting edge. A word of P bits occupies exactly P consecutive valid cycles.
- w, valid, last are registered outputs. No backpressure from the consumer: valid is never stalled once a word is loaded.
- in_valid=0 at the last bit: valid drops to 0 the next cycle and w holds 0.
- Width: cnt is ceil(log2(MAX_WIDTH)) bits and never wraps below 0.

Optional Feature:
POSIT_SER_PREFETCH_EN
- Defined: adds a one-entry prefetch buffer with its own captured word.
  - in_ready = buffer empty, in any state.
  - The buffer is drained into shreg at the last bit, or immediately in IDLE, with the same no-bubble timing.
  - busy also covers a non-empty buffer.
  - set is honoured only when IDLE and the buffer is empty.
  - Reset empties the buffer.
- Undefined: in_ready timing exactly as in Behaviour (IDLE or last-bit cycle only); no buffer storage.

Test Plan:
- Reset, precision default 4, accept in_weight=8'h0B -> w=1,0,1,1 over 4 consecutive valid cycles starting 1 cycle after accept; last=1 on 4th bit only; then valid=0, busy=0.
- Back-to-back: hold in_valid, words 8'h0B then 8'h06 at precision 4 -> 8 contiguous valid bits 1011_0110; in_ready high only on each last-bit cycle; no gap.
- set with precision=8 in IDLE, send 8'h81 -> w=1,0,0,0,0,0,0,1 over 8 cycles, last on 8th; upper bits of a subsequent 4-bit run are not affected.
- set with precision=1 -> word 8'h02 sends 2 bits 1,0 (clamped to 2). set with precision=6 during SHIFT -> ignored; next word still 8 bits.
- Assert rst on the 2nd bit of a precision-4 word -> next cycle valid=0, last=0, busy=0, prec_r=4; a new word then streams normally.
- With POSIT_SER_PREFETCH_EN: in_valid asserted continuously -> in_ready high in the 1st bit cycle of the word in flight (buffer empty). The second word is stored and streams gap-free. The third word's in_ready rises only after the buffer drains.

Source files
------------

// File: rtl/posit_weight_serializer.sv
// Bit-serial transmitter for posit weights: parallel words in, MSB-first bit train out at a run-time precision.
// Optional one-entry prefetch buffer is enabled with `define POSIT_SER_PREFETCH_EN.
module posit_weight_serializer #(
  parameter int MAX_WIDTH    = 8,
  parameter int PREC_WIDTH   = 4,
  parameter int DEFAULT_PREC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set,
  input  logic [PREC_WIDTH-1:0] precision,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAX_WIDTH-1:0]  in_weight,
  output logic                  w,
  output logic                  valid,
  output logic                  last,
  output logic                  busy
);

  localparam int CNT_W = (MAX_WIDTH > 2) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [MAX_WIDTH-1:0]  shreg, shreg_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [PREC_WIDTH-1:0] prec_r, prec_nxt;
  logic                  w_nxt, valid_nxt, last_nxt;
  logic                  hs, load_slot, load_req, set_ok;
  logic [MAX_WIDTH-1:0]  load_word, prec_mask;
  logic [CNT_W-1:0]      top_idx;

`ifdef POSIT_SER_PREFETCH_EN
  logic                  buf_valid, buf_valid_nxt;
  logic [MAX_WIDTH-1:0]  buf_word, buf_word_nxt;
`endif

  function automatic logic [PREC_WIDTH-1:0] clamp_prec(input logic [PREC_WIDTH-1:0] p);
    if (int'(p) < 2)         return PREC_WIDTH'(2);
    if (int'(p) > MAX_WIDTH) return PREC_WIDTH'(MAX_WIDTH);
    return p;
  endfunction

  // Handshake: a word transfers on a rising edge where in_valid & in_ready are both high;
  // in_valid may be raised at any time, in_ready never depends on in_valid, and there is
  // no consumer-side ready: once a word is loaded its bits stream without stalls.
  assign load_slot = (state == IDLE) || (cnt == '0);
  assign hs        = in_valid && in_ready;
  assign top_idx   = CNT_W'(prec_r - 1'b1);
  assign prec_mask = ~({MAX_WIDTH{1'b1}} << prec_r);

`ifdef POSIT_SER_PREFETCH_EN
  assign in_ready = !rst && !buf_valid;
  assign busy     = (state == SHIFT) || buf_valid;
`else
  assign in_ready = !rst && load_slot;
  assign busy     = (state == SHIFT);
`endif

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    prec_nxt  = prec_r;
    w_nxt     = 1'b0;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
`ifdef POSIT_SER_PREFETCH_EN
    buf_valid_nxt = buf_valid;
    buf_word_nxt  = buf_word;
    // A waiting buffered word always wins the load slot; otherwise a new word bypasses the buffer.
    load_req  = load_slot && (buf_valid || hs);
    load_word = buf_valid ? buf_word : in_weight;
    set_ok    = (state == IDLE) && !hs && !buf_valid;
    if (load_slot && buf_valid) buf_valid_nxt = 1'b0;
    if (hs && !load_slot) begin
      buf_valid_nxt = 1'b1;
      buf_word_nxt  = in_weight;
    end
`else
    load_req  = load_slot && hs;
    load_word = in_weight;
    set_ok    = (state == IDLE) && !hs;
`endif

    if (set && set_ok) prec_nxt = clamp_prec(precision);

    // Outputs are registered, so the next bit is picked one cycle ahead: cnt always
    // indexes the bit currently on w.
    if (load_req) begin
      state_nxt = SHIFT;
      shreg_nxt = load_word & prec_mask;
      cnt_nxt   = top_idx;
      w_nxt     = load_word[top_idx];
      valid_nxt = 1'b1;
      last_nxt  = (top_idx == '0);
    end else if (state == SHIFT && cnt != '0) begin
      cnt_nxt   = cnt - 1'b1;
      w_nxt     = shreg[cnt - 1'b1];
      valid_nxt = 1'b1;
      last_nxt  = (cnt == CNT_W'(1));
    end else if (state == SHIFT) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      prec_r <= PREC_WIDTH'(DEFAULT_PREC);
      w      <= 1'b0;
      valid  <= 1'b0;
      last   <= 1'b0;
`ifdef POSIT_SER_PREFETCH_EN
      buf_valid <= 1'b0;
      buf_word  <= '0;
`endif
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      prec_r <= prec_nxt;
      w      <= w_nxt;
      valid  <= valid_nxt;
      last   <= last_nxt;
`ifdef POSIT_SER_PREFETCH_EN
      buf_valid <= buf_valid_nxt;
      buf_word  <= buf_word_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_posit_weight_serializer.sv
// Scoreboard bench for posit_weight_serializer: driver pushes expected {last,w} per bit, monitor pops on valid.
module tb_posit_weight_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set = 1'b0;
  logic [3:0] precision = 4'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_weight = 8'h00;
  logic       in_ready, w, valid, last, busy;

  logic [1:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         last_run = 0;
  int         nw;

  always #5 clk = ~clk;

  posit_weight_serializer #(
    .MAX_WIDTH   (8),
    .PREC_WIDTH  (4),
    .DEFAULT_PREC(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set      (set),
    .precision(precision),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_weight(in_weight),
    .w        (w),
    .valid    (valid),
    .last     (last),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver acts shortly after the falling edge; the monitor samples exactly on it.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push_word(input logic [7:0] d, input int p);
    for (int i = p - 1; i >= 0; i--) exp_q.push_back({(i == 0), d[i]});
  endtask

  task automatic send(input logic [7:0] d, input int p, input bit keep, output int waits);
    int n = 0;
    in_valid  = 1'b1;
    in_weight = d;
    while (in_ready !== 1'b1 && n < 40) begin
`ifndef POSIT_SER_PREFETCH_EN
      check("in_ready_rule", in_ready, (!busy || last));
`endif
      step();
      n++;
    end
    waits = n;
    if (n >= 40) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      set      = 1'b0;
      return;
    end
`ifndef POSIT_SER_PREFETCH_EN
    check("in_ready_rule", in_ready, (!busy || last));
`endif
    push_word(d, p);
    step();
    set = 1'b0;
    if (!keep) in_valid = 1'b0;
    check("first_bit_latency", valid, 1);
  endtask

  task automatic set_prec(input logic [3:0] p);
    set       = 1'b1;
    precision = p;
    step();
    set = 1'b0;
  endtask

  task automatic wait_idle(input int exp_run);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) check("drain_timeout", 0, 1);
    check("drain_valid", valid, 0);
    check("drain_busy", busy, 0);
    check("run_length", last_run, exp_run);
  endtask

  // Monitor: every valid bit must match the head of the queue; a non-final bit must be followed by another.
  initial begin
    int   run = 0;
    logic more = 1'b0;
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (rst) more = 1'b0;
      if (valid === 1'b1) begin
        run++;
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
          more = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check("bit", {last, w}, e);
          more = !e[1];
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        if (more) check("gap_valid", valid, 1);
        more = 1'b0;
        check("idle_out", {last, w}, 2'b00);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_last", last, 0);
    check("rst_w", w, 0);
    rst = 1'b0;
    step();
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);

    // Default precision 4: 0B -> 1011
    send(8'h0B, 4, 1'b0, nw);
    wait_idle(4);

    // Back-to-back with in_valid held: 1011 0110 1101 as one contiguous train
    send(8'h0B, 4, 1'b1, nw);
    send(8'h06, 4, 1'b1, nw);
`ifdef POSIT_SER_PREFETCH_EN
    check("b2b_wait_word2", nw, 0);
`else
    check("b2b_wait_word2", nw, 3);
`endif
    send(8'h0D, 4, 1'b0, nw);
    check("b2b_wait_word3", nw, 3);
    wait_idle(12);

    // Precision changes in IDLE, including clamps
    set_prec(4'd8);
    send(8'h81, 8, 1'b0, nw);
    wait_idle(8);
    set_prec(4'd4);
    send(8'hF5, 4, 1'b0, nw);
    wait_idle(4);
    set_prec(4'd1);
    send(8'h02, 2, 1'b0, nw);
    wait_idle(2);
    set_prec(4'd15);
    send(8'hC3, 8, 1'b0, nw);
    wait_idle(8);

    // set during SHIFT is dropped; precision stays 8
    send(8'hA5, 8, 1'b0, nw);
    set_prec(4'd6);
    wait_idle(8);
    send(8'h3C, 8, 1'b0, nw);
    wait_idle(8);

    // set coincident with a handshake is dropped and not applied later
    set       = 1'b1;
    precision = 4'd2;
    send(8'h96, 8, 1'b0, nw);
    wait_idle(8);
    send(8'h01, 8, 1'b0, nw);
    wait_idle(8);

    // Reset on the 2nd bit of a 4-bit word aborts it
    set_prec(4'd4);
    send(8'h0B, 4, 1'b0, nw);
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    check("abort_valid", valid, 0);
    check("abort_last", last, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_run", last_run, 2);
    rst = 1'b0;
    step();
    send(8'hFB, 4, 1'b0, nw);
    wait_idle(4);

    // Reset restores the default precision of 4
    set_prec(4'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    send(8'hFB, 4, 1'b0, nw);
    wait_idle(4);

    step();
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
